// File: rtl/avalon_st_framer_pkg.sv
// Shared types and constants for the Avalon-ST framer: FSM state encoding,
// default header byte and the packing of one output beat.
package avalon_st_framer_pkg;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } framer_state_t;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
    localparam int         BEAT_W              = 10;

    // One output beat is {sop, eop, data}.
    function automatic logic [BEAT_W-1:0] pack_beat(input logic sop, input logic eop,
                                                    input logic [7:0] data);
        return {sop, eop, data};
    endfunction

endpackage

// File: rtl/avalon_st_out_stage.sv
// Single output register with valid/hold handshake. Loads only when the
// register is free, so a stalled beat stays put until the sink accepts it.
module avalon_st_out_stage
    import avalon_st_framer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BEAT_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_free,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_data
);

    logic              valid_reg;
    logic [BEAT_W-1:0] data_reg;

    assign out_free  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Valid drops when the current beat drains and nothing new is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (out_free) begin
            valid_reg <= load;
            if (load) begin
                data_reg <= load_data;
            end
        end
    end

endmodule

// File: rtl/avalon_st_framer.sv
// Wraps a stream of payload bytes into frames: header, PAYLOAD_LEN bytes,
// then an 8-bit additive checksum, through a single output register.
module avalon_st_framer
    import avalon_st_framer_pkg::*;
#(
    parameter int         PAYLOAD_LEN = 4,
    parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        asi_valid,
    input  logic [7:0]  asi_data,
    output logic        asi_ready,
    output logic        aso_valid,
    output logic [7:0]  aso_data,
    output logic        aso_startofpacket,
    output logic        aso_endofpacket,
    input  logic        aso_ready,
    output logic [15:0] frames_sent
);

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    framer_state_t     state_reg, state_next;
    logic [7:0]        count_reg, count_next;
    logic [7:0]        sum_reg, sum_next;
    logic [15:0]       frames_reg;
    logic              load;
    logic [BEAT_W-1:0] load_data;
    logic              out_free;
    logic [BEAT_W-1:0] out_data;

    avalon_st_out_stage u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .out_ready (aso_ready),
        .out_free  (out_free),
        .out_valid (aso_valid),
        .out_data  (out_data)
    );

    assign aso_startofpacket = out_data[9];
    assign aso_endofpacket   = out_data[8];
    assign aso_data          = out_data[7:0];
    assign frames_sent       = frames_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_HEADER;
            count_reg <= 8'd0;
            sum_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            sum_reg   <= sum_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        sum_next   = sum_reg;
        load       = 1'b0;
        load_data  = '0;
        asi_ready  = 1'b0;
        case (state_reg)
            ST_HEADER: begin
                // A header is only emitted once payload data is actually waiting.
                if (asi_valid && out_free) begin
                    load       = 1'b1;
                    load_data  = pack_beat(1'b1, 1'b0, HEADER_BYTE);
                    count_next = 8'd0;
                    sum_next   = 8'd0;
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                asi_ready = out_free;
                if (asi_valid && out_free) begin
                    load       = 1'b1;
                    load_data  = pack_beat(1'b0, 1'b0, asi_data);
                    sum_next   = sum_reg + asi_data;
                    count_next = count_reg + 8'd1;
                    if (count_reg == LAST_IDX) begin
                        state_next = ST_TRAILER;
                    end
                end
            end
            ST_TRAILER: begin
                if (out_free) begin
                    load       = 1'b1;
                    load_data  = pack_beat(1'b0, 1'b1, sum_reg);
                    state_next = ST_HEADER;
                end
            end
            default: begin
                state_next = ST_HEADER;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_reg <= 16'd0;
        end else if (aso_valid && aso_ready && aso_endofpacket) begin
            frames_reg <= frames_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_avalon_st_framer.sv
// Directed bench for avalon_st_framer (PAYLOAD_LEN=4, header A5): output
// transfers are logged at the falling edge and compared against hand-built frames.
module tb_avalon_st_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        asi_valid;
    logic [7:0]  asi_data;
    logic        asi_ready;
    logic        aso_valid;
    logic [7:0]  aso_data;
    logic        aso_startofpacket;
    logic        aso_endofpacket;
    logic        aso_ready;
    logic [15:0] frames_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] cap_data[$];
    logic       cap_sop[$];
    logic       cap_eop[$];
    int         cap_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_sop[$];
    logic       exp_eop[$];

    avalon_st_framer #(.PAYLOAD_LEN(4), .HEADER_BYTE(8'hA5)) dut (
        .clk               (clk),
        .reset             (reset),
        .asi_valid         (asi_valid),
        .asi_data          (asi_data),
        .asi_ready         (asi_ready),
        .aso_valid         (aso_valid),
        .aso_data          (aso_data),
        .aso_startofpacket (aso_startofpacket),
        .aso_endofpacket   (aso_endofpacket),
        .aso_ready         (aso_ready),
        .frames_sent       (frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change shortly after a rising edge, so valid&&ready seen
    // here is exactly what the next rising edge transfers.
    always @(negedge clk) begin
        if (reset && aso_valid && aso_ready) begin
            cap_data.push_back(aso_data);
            cap_sop.push_back(aso_startofpacket);
            cap_eop.push_back(aso_endofpacket);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n;
        asi_valid = 1'b1;
        asi_data  = d;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (asi_ready) break;
        end
        check("accept_in_time", 16'(n < 100), 16'd1);
        @(posedge clk);
        #1;
        asi_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic exp_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] cs);
        exp_data.push_back(8'hA5); exp_sop.push_back(1'b1); exp_eop.push_back(1'b0);
        exp_data.push_back(b0);    exp_sop.push_back(1'b0); exp_eop.push_back(1'b0);
        exp_data.push_back(b1);    exp_sop.push_back(1'b0); exp_eop.push_back(1'b0);
        exp_data.push_back(b2);    exp_sop.push_back(1'b0); exp_eop.push_back(1'b0);
        exp_data.push_back(b3);    exp_sop.push_back(1'b0); exp_eop.push_back(1'b0);
        exp_data.push_back(cs);    exp_sop.push_back(1'b0); exp_eop.push_back(1'b1);
    endtask

    // Waits for every expected beat (bounded), then compares and clears the logs.
    task automatic check_stream(input string tag, input bit contig);
        int k;
        for (k = 0; k < 200 && cap_data.size() < exp_data.size(); k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_len"}, 16'(cap_data.size()), 16'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), {8'h00, cap_data[i]}, {8'h00, exp_data[i]});
            check($sformatf("%s_sop%0d", tag, i), {15'd0, cap_sop[i]}, {15'd0, exp_sop[i]});
            check($sformatf("%s_eop%0d", tag, i), {15'd0, cap_eop[i]}, {15'd0, exp_eop[i]});
            if (contig && i > 0)
                check($sformatf("%s_gap%0d", tag, i), 16'(cap_cyc[i] - cap_cyc[i-1]), 16'd1);
        end
        $display("%s: %0d beats compared", tag, exp_data.size());
        cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_cyc.delete();
        exp_data.delete(); exp_sop.delete(); exp_eop.delete();
    endtask

    initial begin
        reset     = 1'b0;
        asi_valid = 1'b0;
        asi_data  = 8'h00;
        aso_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aso_valid", {15'd0, aso_valid}, 16'd0);
        check("rst_aso_data", {8'd0, aso_data}, 16'h0000);
        check("rst_sop", {15'd0, aso_startofpacket}, 16'd0);
        check("rst_eop", {15'd0, aso_endofpacket}, 16'd0);
        check("rst_frames", frames_sent, 16'd0);
        check("rst_asi_ready", {15'd0, asi_ready}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // No header while upstream is idle
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("idle_no_header", {15'd0, aso_valid}, 16'd0);
        @(posedge clk);
        #1;

        // Basic frame
        exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04);
        check_stream("basic", 1'b1);
        check("basic_frames", frames_sent, 16'd1);

        // Checksum wrap
        exp_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check_stream("wrap", 1'b0);
        check("wrap_frames", frames_sent, 16'd2);

        // Downstream stall for 3 cycles while 02 is on the output
        exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        fork
            send_frame(8'h01, 8'h02, 8'h03, 8'h04);
            begin
                int w;
                for (w = 0; w < 100; w++) begin
                    @(posedge clk);
                    #2;
                    if (aso_valid && aso_data == 8'h02) break;
                end
                check("stall_seen_02", 16'(w < 100), 16'd1);
                aso_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check($sformatf("stall_hold_data%0d", s), {8'd0, aso_data}, 16'h0002);
                    check($sformatf("stall_hold_valid%0d", s), {15'd0, aso_valid}, 16'd1);
                    check($sformatf("stall_asi_ready%0d", s), {15'd0, asi_ready}, 16'd0);
                    @(posedge clk);
                end
                #2;
                aso_ready = 1'b1;
            end
        join
        check_stream("stall", 1'b0);
        check("stall_frames", frames_sent, 16'd3);

        // Back-to-back frames, no bubble
        exp_frame(8'h10, 8'h11, 8'h12, 8'h13, 8'h46);
        exp_frame(8'h20, 8'h21, 8'h22, 8'h23, 8'h86);
        send_frame(8'h10, 8'h11, 8'h12, 8'h13);
        send_frame(8'h20, 8'h21, 8'h22, 8'h23);
        check_stream("b2b", 1'b1);
        check("b2b_frames", frames_sent, 16'd5);

        // Reset mid-frame discards the partial frame
        send_byte(8'h31);
        send_byte(8'h32);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_aso_valid", {15'd0, aso_valid}, 16'd0);
        check("midrst_asi_ready", {15'd0, asi_ready}, 16'd0);
        check("midrst_frames", frames_sent, 16'd0);
        @(negedge clk);
        check("midrst_aso_valid2", {15'd0, aso_valid}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_cyc.delete();
        exp_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
        send_frame(8'h05, 8'h06, 8'h07, 8'h08);
        check_stream("postrst", 1'b1);
        check("postrst_frames", frames_sent, 16'd1);

        // Upstream gaps of 2 cycles between payload bytes
        exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        for (int g = 0; g < 4; g++) begin
            send_byte(8'(g + 1));
            if (g < 3) begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("gap_valid_low%0d", g), {15'd0, aso_valid}, 16'd0);
                @(posedge clk);
                #1;
            end
        end
        check_stream("gaps", 1'b0);
        check("gaps_frames", frames_sent, 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
